// File: rtl/ntt_stage_sequencer.sv
// Stage sequencer for a multi-core forward NTT: issues per-stage read addresses,
// drains the butterfly pipeline between stages and delays strobes into write-backs.
module ntt_stage_sequencer #(
    parameter int LOG_CORE_COUNT = 5,
    parameter int LOG_N          = 11,
    parameter int PIPE_STAGES    = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       load_active,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [3:0] log_m,
    output logic [3:0] log_t,
    output logic [9:0] i,
    output logic [8:0] read_address,
    output logic       read_valid,
    output logic       write_enable,
    output logic [8:0] write_address
);

    localparam int LOG_R = LOG_N - 1 - LOG_CORE_COUNT;
    localparam int R     = 1 << LOG_R;
    localparam int DW    = (PIPE_STAGES > 1) ? $clog2(PIPE_STAGES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    state_e          state_q, state_d;
    logic [3:0]      logm_q, logm_d;
    logic [8:0]      addr_q, addr_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic [9:0]      grp_q, grp_d;
    logic            loadPrev_q;
    logic [PIPE_STAGES-1:0] rvPipe_q;
    logic [8:0]      addrPipe_q [PIPE_STAGES];

    logic            cancel;
    int              gexp;
    logic [8:0]      stepMask;
    logic [9:0]      grpMask;

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign read_valid    = (state_q == ISSUE);
    assign read_address  = addr_q;
    assign log_m         = logm_q;
    assign log_t         = 4'(LOG_N - 1) - logm_q;
    assign i             = grp_q;
    assign write_enable  = rvPipe_q[PIPE_STAGES-1];
    assign write_address = addrPipe_q[PIPE_STAGES-1];

    // A load starting mid-run is as fatal to the transform as an explicit abort.
    assign cancel = busy && (abort || (load_active && !loadPrev_q));

    always_comb begin
        state_d  = state_q;
        logm_d   = logm_q;
        addr_d   = addr_q;
        drain_d  = drain_q;
        grp_d    = grp_q;
        gexp     = (int'(logm_q) >= LOG_CORE_COUNT) ? int'(logm_q) - LOG_CORE_COUNT : 0;
        if (gexp > LOG_R) gexp = LOG_R;
        stepMask = 9'((32'd1 << (LOG_R - gexp)) - 32'd1);
        grpMask  = 10'((32'd1 << gexp) - 32'd1);

        case (state_q)
            IDLE: begin
                if (start && !load_active) begin
                    state_d = ISSUE;
                    logm_d  = '0;
                    addr_d  = '0;
                    grp_d   = '0;
                end
            end
            ISSUE: begin
                addr_d = addr_q + 9'd1;
                // Group index advances once every R/G addresses and wraps at G.
                if ((addr_q & stepMask) == stepMask) grp_d = (grp_q + 10'd1) & grpMask;
                if (addr_q == 9'(R - 1)) begin
                    state_d = DRAIN;
                    drain_d = '0;
                    addr_d  = '0;
                end
            end
            DRAIN: begin
                drain_d = drain_q + DW'(1);
                if (drain_q == DW'(PIPE_STAGES - 1)) begin
                    if (logm_q == 4'(LOG_N - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        logm_d  = logm_q + 4'd1;
                        addr_d  = '0;
                        grp_d   = '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                logm_d  = '0;
                grp_d   = '0;
            end
            default: state_d = IDLE;
        endcase

        if (cancel) begin
            state_d = IDLE;
            logm_d  = '0;
            addr_d  = '0;
            drain_d = '0;
            grp_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            logm_q     <= '0;
            addr_q     <= '0;
            drain_q    <= '0;
            grp_q      <= '0;
            loadPrev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            logm_q     <= logm_d;
            addr_q     <= addr_d;
            drain_q    <= drain_d;
            grp_q      <= grp_d;
            loadPrev_q <= load_active;
        end
    end

    // Write-back delay line runs in every state so the last stage retires during its drain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvPipe_q <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) addrPipe_q[k] <= '0;
        end else if (cancel) begin
            rvPipe_q <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) addrPipe_q[k] <= '0;
        end else begin
            rvPipe_q[0]   <= read_valid;
            addrPipe_q[0] <= read_address;
            for (int k = 1; k < PIPE_STAGES; k++) begin
                rvPipe_q[k]   <= rvPipe_q[k-1];
                addrPipe_q[k] <= addrPipe_q[k-1];
            end
        end
    end

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Directed bench for ntt_stage_sequencer at default parameters: full run timing,
// group index pattern, start blocking, abort and asynchronous reset behaviour.
module tb_ntt_stage_sequencer;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       load_active;
    logic       abort;
    logic       busy;
    logic       done;
    logic [3:0] log_m;
    logic [3:0] log_t;
    logic [9:0] i;
    logic [8:0] read_address;
    logic       read_valid;
    logic       write_enable;
    logic [8:0] write_address;

    int vecCount  = 0;
    int missCount = 0;

    ntt_stage_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .load_active  (load_active),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .log_m        (log_m),
        .log_t        (log_t),
        .i            (i),
        .read_address (read_address),
        .read_valid   (read_valid),
        .write_enable (write_enable),
        .write_address(write_address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vecCount++;
        if (observed != expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_rv"}, int'(read_valid), 0);
        checkOutput({tag, "_we"}, int'(write_enable), 0);
        checkOutput({tag, "_logm"}, int'(log_m), 0);
        checkOutput({tag, "_logt"}, int'(log_t), 10);
        checkOutput({tag, "_i"}, int'(i), 0);
        checkOutput({tag, "_ra"}, int'(read_address), 0);
        checkOutput({tag, "_wa"}, int'(write_address), 0);
    endtask

    // Pulse start from IDLE; returns at the first ISSUE cycle.
    task automatic applyStimulus();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int reads;
        int writes;
        int lastWrite;
        int stage;
        int off;
        int g;
        int stepLen;
        int w;
        bit expWe;

        reset_n     = 1'b0;
        start       = 1'b0;
        load_active = 1'b0;
        abort       = 1'b0;
        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Full nominal run with a second start injected mid-run.
        applyStimulus();
        reads     = 0;
        writes    = 0;
        lastWrite = -100;
        for (int c = 0; c <= 463; c++) begin
            stage = c / 42;
            off   = c % 42;
            if (c < 462) begin
                checkOutput("run_busy", int'(busy), 1);
                checkOutput("run_done", int'(done), 0);
                checkOutput("run_logm", int'(log_m), stage);
                checkOutput("run_logt", int'(log_t), 10 - stage);
                checkOutput("run_rv", int'(read_valid), (off < 32) ? 1 : 0);
                if (off < 32) begin
                    g       = (stage >= 5) ? (1 << (stage - 5)) : 1;
                    stepLen = 32 / g;
                    checkOutput("run_ra", int'(read_address), off);
                    checkOutput("run_i", int'(i), (off / stepLen) % g);
                end
                if (off == 0 && stage > 0) begin
                    checkOutput("hazard_pending", reads - writes, 0);
                    checkOutput("hazard_gap", (c - lastWrite >= 1) ? 1 : 0, 1);
                end
            end else if (c == 462) begin
                checkOutput("done_pulse", int'(done), 1);
                checkOutput("done_busy", int'(busy), 1);
                checkOutput("done_rv", int'(read_valid), 0);
            end else begin
                checkOutput("post_done", int'(done), 0);
                checkOutput("post_busy", int'(busy), 0);
                checkOutput("post_logm", int'(log_m), 0);
            end
            w     = c - 10;
            expWe = (w >= 0) && (w < 462) && ((w % 42) < 32);
            checkOutput("run_we", int'(write_enable), expWe ? 1 : 0);
            if (expWe) checkOutput("run_wa", int'(write_address), w % 42);
            if (read_valid) reads++;
            if (write_enable) begin
                writes++;
                lastWrite = c;
            end
            start = (c == 100);
            @(negedge clk);
        end
        checkOutput("run_total_writes", writes, 352);

        // Start must be refused while a coefficient load is in progress.
        load_active = 1'b1;
        start       = 1'b1;
        @(negedge clk);
        checkOutput("load_block_busy", int'(busy), 0);
        @(negedge clk);
        checkOutput("load_block_busy2", int'(busy), 0);
        start       = 1'b0;
        load_active = 1'b0;
        @(negedge clk);

        // Abort in the middle of stage 3's issue phase.
        applyStimulus();
        repeat (136) @(negedge clk);
        checkOutput("abort_pre_logm", int'(log_m), 3);
        checkOutput("abort_pre_rv", int'(read_valid), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_we", int'(write_enable), 0);
        checkOutput("abort_done", int'(done), 0);
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            checkOutput("abort_quiet_done", int'(done), 0);
            checkOutput("abort_quiet_we", int'(write_enable), 0);
        end
        applyStimulus();
        checkOutput("restart_logm", int'(log_m), 0);
        checkOutput("restart_rv", int'(read_valid), 1);
        checkOutput("restart_ra", int'(read_address), 0);

        // A load beginning mid-run cancels it like an abort.
        repeat (5) @(negedge clk);
        load_active = 1'b1;
        @(negedge clk);
        checkOutput("loadabort_busy", int'(busy), 0);
        checkOutput("loadabort_we", int'(write_enable), 0);
        load_active = 1'b0;
        @(negedge clk);

        // Asynchronous reset during stage 7's drain.
        applyStimulus();
        repeat (329) @(negedge clk);
        checkOutput("rst_pre_logm", int'(log_m), 7);
        checkOutput("rst_pre_rv", int'(read_valid), 0);
        checkOutput("rst_pre_we", int'(write_enable), 1);
        #2 reset_n = 1'b0;
        #1;
        checkResetOutputs("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            checkOutput("midrst_quiet_done", int'(done), 0);
            checkOutput("midrst_quiet_busy", int'(busy), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/ntt_stage_sequencer.md
NTT_STAGE_SEQUENCER -- requirements
Module: ntt_stage_sequencer

Interface
REQ-001 SHALL have parameter LOG_CORE_COUNT, default 5, meaning log2 of the number of butterfly cores.
REQ-002 SHALL have parameter LOG_N, default 11, meaning log2 of the polynomial length; the stage count is LOG_N.
REQ-003 SHALL have parameter PIPE_STAGES, default 10, meaning the core read-to-write pipeline depth in cycles.
REQ-004 SHALL derive R = 2^(LOG_N-1-LOG_CORE_COUNT), the per-core words per memory, which is 32 at the defaults.
REQ-005 One clock; reset is asynchronous and active-low. Port clk, input, 1: rising-edge clock.
REQ-006 reset_n, input, 1: asynchronous active-low reset.
REQ-007 start, input, 1: request one full forward NTT; sampled only in IDLE.
REQ-008 load_active, input, 1: processor coefficient load in progress; blocks start.
REQ-009 abort, input, 1: synchronous cancel.
REQ-010 busy, output, 1: high in every state except IDLE.
REQ-011 done, output, 1: one-cycle completion pulse.
REQ-012 log_m, output, 4: current stage index 0..LOG_N-1.
REQ-013 log_t, output, 4: LOG_N-1-log_m.
REQ-014 i, output, 10: twiddle group index presented to the cores.
REQ-015 read_address, output, R-width (9 bits max, zero-extended): core read address, driven to upper and lower banks alike.
REQ-016 read_valid, output, 1: read_address is issued this cycle.
REQ-017 write_enable, output, 1: core write-back strobe, driven to upper and lower banks alike.
REQ-018 write_address, output, 9: core write-back address.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, DRAIN and DONE.
REQ-020 IDLE: when start=1 and load_active=0, go to ISSUE next cycle with log_m=0, log_t=LOG_N-1, address counter 0 and i=0. Otherwise stay in IDLE.
REQ-021 ISSUE: read_valid=1 and read_address=counter. The counter increments each cycle. After the cycle with counter=R-1, go to DRAIN with the drain counter at 0.
REQ-022 DRAIN: read_valid=0; hold for exactly PIPE_STAGES cycles. This guarantees every write-back of stage s lands before any read of stage s+1.
REQ-023 End of DRAIN: if log_m=LOG_N-1, go to DONE. Otherwise go to ISSUE with log_m+1, log_t-1, counter 0 and i=0.
REQ-024 Each stage SHALL occupy exactly R+PIPE_STAGES cycles, which is 42 at the defaults.
REQ-025 DONE lasts one cycle with done=1, then returns to IDLE. At the defaults, done asserts 462 cycles after the first ISSUE cycle.
REQ-026 G = 2^(log_m-LOG_CORE_COUNT) if log_m>=LOG_CORE_COUNT, else 1. The i output increments after every R/G issued addresses and wraps to 0 at G. When G>R, i increments every cycle modulo G.
REQ-027 write_enable and write_address SHALL equal read_valid and read_address delayed by exactly PIPE_STAGES cycles through a shift register.
REQ-028 The write-back shift register runs in all states, so the writes of the final stage complete during DRAIN.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 abort=1 in any non-IDLE state: next cycle state=IDLE, shift register cleared, write_enable=0, done stays 0. abort in IDLE has no effect.
REQ-031 abort has priority over all other transitions in the same cycle.
REQ-032 load_active rising while busy SHALL be treated as abort.

Reset
REQ-033 reset_n=0 SHALL immediately force: state=IDLE, busy=0, done=0, read_valid=0, write_enable=0, log_m=0, log_t=LOG_N-1, i=0, read_address=0, write_address=0, and the shift register cleared.
REQ-034 Reset mid-run SHALL discard the run; no done pulse is emitted.

Verification
REQ-035 start pulse in IDLE, defaults -> read_valid high for 32 cycles (addresses 0..31). The first write_enable arrives 10 cycles after the first read_valid. 11 stages complete, then a single done pulse 462 cycles after the first ISSUE cycle.
REQ-036 Per-stage i check -> log_m=5: i=0 throughout. log_m=6: i=0 for 16 cycles, then i=1. log_m=10: i increments every cycle 0..31.
REQ-037 start with load_active=1 -> busy stays 0. A second start during a run -> ignored, and the run length is still 462.
REQ-038 abort in stage 3 mid-ISSUE -> next cycle busy=0, write_enable=0, no done pulse. A new start then begins at log_m=0.
REQ-039 reset_n low during DRAIN of stage 7 -> all outputs match REQ-033 asynchronously, before the next edge.
REQ-040 Hazard check -> no read of stage s+1 occurs while write_enable for stage s is pending; verified by an assertion on the gap from the last write of stage s to the first read of stage s+1, which must be at least 1 cycle.
